// File: rtl/window_feeder.sv
// img2col window producer: streams pixels into the 25-entry window bank, paced by r_ctrl_g.
// Optional build macro WINDOW_FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module window_feeder #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 5,
    parameter int ROUNDS_PER_ROW = 24,
    parameter int ROWS           = 24
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  go,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    input  logic                  r_ctrl_g,
    output logic                  start,
    output logic                  wr_ctrl_g,
    output logic [ADDR_WIDTH-1:0] adrs_in1,
    output logic [DATA_WIDTH-1:0] data_g,
    output logic [5:0]            round,
    output logic                  busy,
    output logic                  done
`ifdef WINDOW_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_FILL    = 3'd2,
        ST_WAIT_RD = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [5:0]            LAST_ROUND = 6'(ROUNDS_PER_ROW - 1);
    localparam logic [15:0]           LAST_ROW   = 16'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(24);
    localparam logic [ADDR_WIDTH-1:0] ADDR_COL   = ADDR_WIDTH'(20);

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [5:0]              round_r;
    logic [15:0]             row_r;
    logic                    seen_r;
    logic                    pix_ready_r, start_r, busy_r, done_r;
    logic                    pix_ready_s, start_s, busy_s, done_s;
    logic                    wr_ctrl_g_r;
    logic [ADDR_WIDTH-1:0]   adrs_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    hs_s, fall_s, last_s;

    // pix_ready_r is high exactly while in FILL, so it also qualifies the handshake
    assign hs_s   = (state_r == ST_FILL) && pix_valid && pix_ready_r;
    // Falling phase of r_ctrl_g: a high seen earlier in WAIT_RD (entry cycle included), now low
    assign fall_s = (state_r == ST_WAIT_RD) && seen_r && !r_ctrl_g;
    assign last_s = (round_r == LAST_ROUND) && (row_r == LAST_ROW);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:    if (go) state_s = ST_START; else state_s = ST_IDLE;
            ST_START:   state_s = ST_FILL;
            ST_FILL:    if (hs_s && (addr_r == ADDR_LAST)) state_s = ST_WAIT_RD; else state_s = ST_FILL;
            ST_WAIT_RD: begin
                if (fall_s) begin
                    if (last_s) state_s = ST_DONE; else state_s = ST_FILL;
                end else begin
                    state_s = ST_WAIT_RD;
                end
            end
            ST_DONE:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered below so outputs align with the state
    always_comb begin
        pix_ready_s = 1'b0;
        start_s     = 1'b0;
        busy_s      = 1'b1;
        done_s      = 1'b0;
        case (state_s)
            ST_IDLE:    busy_s      = 1'b0;
            ST_START:   start_s     = 1'b1;
            ST_FILL:    pix_ready_s = 1'b1;
            ST_WAIT_RD: pix_ready_s = 1'b0;
            ST_DONE:    done_s      = 1'b1;
            default:    busy_s      = 1'b0;
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pix_ready_r <= 1'b0;
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pix_ready_r <= pix_ready_s;
            start_r     <= start_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Window counters: address within the bank, window index, row index
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_r  <= '0;
            round_r <= 6'd0;
            row_r   <= 16'd0;
            seen_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_START: begin
                    addr_r  <= '0;
                    round_r <= 6'd0;
                    row_r   <= 16'd0;
                    seen_r  <= 1'b0;
                end
                ST_FILL: begin
                    if (hs_s && (addr_r != ADDR_LAST)) addr_r <= addr_r + ADDR_WIDTH'(1);
                end
                ST_WAIT_RD: begin
                    if (fall_s) begin
                        seen_r <= 1'b0;
                        if (round_r != LAST_ROUND) begin
                            round_r <= round_r + 6'd1;
                            addr_r  <= ADDR_COL;
                        end else if (row_r != LAST_ROW) begin
                            round_r <= 6'd0;
                            row_r   <= row_r + 16'd1;
                            addr_r  <= '0;
                        end
                    end else if (r_ctrl_g) begin
                        seen_r <= 1'b1;
                    end
                end
                default: seen_r <= 1'b0;
            endcase
        end
    end

    // Window bank write port, one cycle behind the accepting handshake
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ctrl_g_r <= 1'b0;
            adrs_r      <= '0;
            data_r      <= '0;
        end else begin
            wr_ctrl_g_r <= hs_s;
            if (hs_s) begin
                adrs_r <= addr_r;
                data_r <= pix_data;
            end
        end
    end

`ifdef WINDOW_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of FILL cycles where the stream had nothing to offer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt_r <= 16'd0;
        end else if (state_r == ST_START) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == ST_FILL) && pix_ready_r && !pix_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign pix_ready = pix_ready_r;
    assign start     = start_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign wr_ctrl_g = wr_ctrl_g_r;
    assign adrs_in1  = adrs_r;
    assign data_g    = data_r;
    assign round     = round_r;

endmodule

// File: tb/tb_window_feeder.sv
// Randomized bench for window_feeder: a window-level model predicts every bank write and round value.
module tb_window_feeder;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int RPR   = 3;
    localparam int NROWS = 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          go = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          r_ctrl_g = 1'b0;
    logic          start, wr_ctrl_g, busy, done;
    logic [AW-1:0] adrs_in1;
    logic [DW-1:0] data_g;
    logic [5:0]    round;
`ifdef WINDOW_FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    window_feeder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROUNDS_PER_ROW(RPR), .ROWS(NROWS)
    ) dut (
        .clk(clk), .nrst(nrst), .go(go), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .r_ctrl_g(r_ctrl_g), .start(start), .wr_ctrl_g(wr_ctrl_g),
        .adrs_in1(adrs_in1), .data_g(data_g), .round(round), .busy(busy), .done(done)
`ifdef WINDOW_FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int checks = 0;
    int passed = 0;

    // Model state: position inside the current window and expected bank writes
    int            m_round, m_row, m_pos, m_stall;
    bit            m_full;
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_clear();
        m_round = 0; m_row = 0; m_pos = 0; m_full = 1'b0; m_stall = 0;
        q_addr.delete(); q_data.delete();
    endtask

    // One clock: predict the handshake from inputs before the edge, check the write after it
    task automatic tick();
        bit hs;
        int base, len;
        hs   = pix_valid && pix_ready;
        base = (m_round == 0) ? 0 : 20;
        len  = (m_round == 0) ? 25 : 5;
        if (pix_ready && !pix_valid && m_stall < 65535) m_stall++;
        if (hs) begin
            if (m_full) check_val("accept_when_full", 32'(pix_ready), 32'd0);
            q_addr.push_back(AW'(base + m_pos));
            q_data.push_back(pix_data);
            m_pos++;
            if (m_pos == len) m_full = 1'b1;
        end
        @(negedge clk);
        check_val("wr_en", 32'(wr_ctrl_g), 32'(hs));
        if (wr_ctrl_g && q_addr.size() > 0) begin
            check_val("wr_addr", 32'(adrs_in1), 32'(q_addr.pop_front()));
            check_val("wr_data", 32'(data_g), 32'(q_data.pop_front()));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, 32'(pix_ready), 32'd0);
        check_val({tag, "_start"}, 32'(start), 32'd0);
        check_val({tag, "_wr"}, 32'(wr_ctrl_g), 32'd0);
        check_val({tag, "_addr"}, 32'(adrs_in1), 32'd0);
        check_val({tag, "_data"}, 32'(data_g), 32'd0);
        check_val({tag, "_round"}, 32'(round), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic begin_frame();
        model_clear();
        go = 1'b1;
        tick();
        check_val("start_pulse", 32'(start), 32'd1);
        check_val("busy_start", 32'(busy), 32'd1);
        go = 1'b0;
        tick();
        check_val("start_once", 32'(start), 32'd0);
        check_val("ready_fill", 32'(pix_ready), 32'd1);
        check_val("round_first", 32'(round), 32'd0);
    endtask

    task automatic run_frame(input bit dense);
        bit last;
        begin_frame();
        last = 1'b0;
        for (int w = 0; w < RPR * NROWS; w++) begin
            int n, pre, hi;
            n = 0;
            while (!m_full && n < 300) begin
                pix_valid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
                pix_data  = DW'($urandom);
                go        = ($urandom_range(0, 7) == 0);
                tick();
                check_val("start_ignored", 32'(start), 32'd0);
                n++;
            end
            check_val("fill_complete", 32'(m_full), 32'd1);
            go        = 1'b0;
            pix_valid = $urandom_range(0, 1);
            pix_data  = DW'($urandom);
            pre       = $urandom_range(0, 2);
            hi        = $urandom_range(1, 3);
            for (int i = 0; i < pre; i++) begin
                tick();
                check_val("ready_wait_lo", 32'(pix_ready), 32'd0);
            end
            r_ctrl_g = 1'b1;
            for (int i = 0; i < hi; i++) begin
                tick();
                check_val("ready_wait_hi", 32'(pix_ready), 32'd0);
            end
            r_ctrl_g = 1'b0;
            tick();
            m_pos  = 0;
            m_full = 1'b0;
            if (m_round < RPR - 1) m_round++;
            else if (m_row < NROWS - 1) begin m_round = 0; m_row++; end
            else last = 1'b1;
            if (last) begin
                check_val("done_pulse", 32'(done), 32'd1);
                check_val("busy_done", 32'(busy), 32'd1);
                check_val("round_hold", 32'(round), 32'(RPR - 1));
                pix_valid = 1'b0;
                tick();
                check_val("done_once", 32'(done), 32'd0);
                check_val("busy_drop", 32'(busy), 32'd0);
                check_val("ready_idle", 32'(pix_ready), 32'd0);
                check_val("round_idle", 32'(round), 32'(RPR - 1));
            end else begin
                check_val("ready_next", 32'(pix_ready), 32'd1);
                check_val("round_next", 32'(round), 32'(m_round));
                check_val("done_early", 32'(done), 32'd0);
            end
        end
        check_val("queue_empty", 32'(q_addr.size()), 32'd0);
`ifdef WINDOW_FEEDER_STALL_CNT_EN
        check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    initial begin
        model_clear();
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_all_zero("rst");
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_all_zero("rst_rel");

        run_frame(1'b1);
        run_frame(1'b0);

        // Reset in the middle of the first window, after address 12 has been written
        begin_frame();
        pix_valid = 1'b1;
        for (int i = 0; i < 60 && m_pos < 13; i++) begin
            pix_data = DW'($urandom);
            tick();
        end
        check_val("mid_pos", 32'(m_pos), 32'd13);
        #1 nrst = 1'b0;
        #1 check_all_zero("rst_mid");
        model_clear();
        pix_valid = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        check_all_zero("rst_mid_rel");
        run_frame(1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/window_feeder.md
# window_feeder

Producer side of the img2col window-register handshake. Accepts a pixel stream from the feature-map buffer and writes 5x5 convolution windows into the 25-entry window register bank read by the PU control FSM: a full window (addresses 0..24) on the first window of each row, only the new column (addresses 20..24) on later windows. It generates the controller's `start`, `wr_ctrl_g`, `adrs_in1` and `round` inputs, and paces itself on the controller's `r_ctrl_g` read strobe.

## Interface
- DATA_WIDTH, 16, pixel width
- ADDR_WIDTH, 5, window bank address width
- ROUNDS_PER_ROW, 24, window positions per image row (1..64)
- ROWS, 24, window rows per frame (1..65535)

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- go  in  1  frame start pulse; ignored while busy
- pix_valid  in  1  stream data valid
- pix_data  in  DATA_WIDTH  pixel; window column-major, address = 5*col + row
- pix_ready  out  1  stream ready
- r_ctrl_g  in  1  controller window-bank read strobe
- start  out  1  one-cycle start pulse to controller
- wr_ctrl_g  out  1  window bank write enable
- adrs_in1  out  ADDR_WIDTH  window bank write address
- data_g  out  DATA_WIDTH  window bank write data
- round  out  6  window index within current row
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last window read

## Operation
- States: IDLE, START, FILL, WAIT_RD, DONE.
- IDLE: busy=0, pix_ready=0. go=1 -> START.
- START: start=1 for this cycle only; round<=0, row<=0, addr<=0 -> FILL.
- FILL: pix_ready=1. Each pix_valid&&pix_ready handshake writes pix_data to address addr, then addr++. Handshake accepted at addr=24 -> WAIT_RD, with pix_ready=0 from the following cycle.
- WAIT_RD: pix_ready=0. Waits for r_ctrl_g to go 1, then 0 (falling edge: the controller has finished read_g/write_r and returned to write_g). Then:
  - round < ROUNDS_PER_ROW-1: round++, addr<=20 -> FILL.
  - round = ROUNDS_PER_ROW-1, row < ROWS-1: round<=0, row++, addr<=0 -> FILL.
  - otherwise -> DONE.
- DONE: done=1 for one cycle -> IDLE. round holds its last value until the next START.
- Counters: addr 5-bit, never exceeds 24. round 6-bit, wraps only through ROUNDS_PER_ROW. row 16-bit.
- Boundary cases:
  - go while busy: ignored.
  - pix_valid outside FILL: not accepted.
  - r_ctrl_g already high on entry to WAIT_RD: counts as the rising phase.
  - ROUNDS_PER_ROW=1: every window is a full 25-write fill.
  - nrst low at any time: immediate return to IDLE, all outputs 0. The controller must be reset together with this block.

## Timing
- Reset values: pix_ready=0, start=0, wr_ctrl_g=0, adrs_in1=0, data_g=0, round=0, busy=0, done=0.
- wr_ctrl_g, adrs_in1 and data_g are registered: a handshake in cycle N produces the write in cycle N+1. wr_ctrl_g is high exactly one cycle per accepted pixel.
- First possible write is 2 cycles after start, which guarantees the controller is already in write_g.
- round updates in the cycle after the r_ctrl_g falling edge, before the next window's first write.
- busy=1 from START through DONE inclusive.
- Sustained throughput: 1 pixel/cycle in FILL. Window turnaround is the WAIT_RD wait plus 1 cycle.

## Configuration
- WINDOW_FEEDER_STALL_CNT_EN defined:
  - Adds output stall_cnt [15:0], saturating.
  - Counts FILL cycles with pix_ready=1 and pix_valid=0.
  - Cleared in START and on reset.
- Macro undefined: port and counter absent. All other behaviour identical.

## Test plan
- Reset: hold nrst=0 for 3 cycles -> every output 0, state IDLE. Release with go=0 -> outputs stay 0.
- Full fill: go, stream pixels 1..25 back-to-back -> start pulses once, writes to addresses 0..24 with data 1..25 one cycle after each handshake, pix_ready=0 after the 25th pixel.
- Column update: drive r_ctrl_g high 2 cycles then low, stream 26..30 -> round=1, writes to addresses 20..24 only with data 26..30. No pixel is accepted before the r_ctrl_g fall.
- Row wrap: ROUNDS_PER_ROW=3, ROWS=2 -> round sequence 0,1,2,0,1,2; fills of 25,5,5,25,5,5 writes; done pulses one cycle after the final r_ctrl_g fall; busy then drops.
- Bursty stream: toggle pix_valid 1,0,0,1,... -> wr_ctrl_g gaps match the input gaps, addresses stay contiguous. With WINDOW_FEEDER_STALL_CNT_EN, stall_cnt equals the number of idle valid cycles.
- Reset mid-fill: assert nrst=0 after address 12 is written -> outputs 0 immediately. After release, go restarts at address 0 with round=0.
